display_scan_ctrl: RTL and testbench

Time-multiplexes the single shared BCD-to-7-segment decoder across N common-anode digits of the result display of the 4-bit adder/subtractor.
Holds a frame buffer of N nibbles and drives the decoder input with one nibble per scan slot. Registers the decoder's segment output and drives active-low anode enables, with a blanking guard against ghosting.
New display values are accepted via a load/ack handshake and committed only at frame boundaries, so a frame never shows mixed old and new digits.

---
 rtl/display_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, N common-anode digits,
// blanking guard per slot, frame-boundary commit of new values via load/ack.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic                  ack,
  output logic [3:0]            dec_in,
  input  logic [0:6]            seg_in,
  output logic [0:6]            seg_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned BUF_W = 4 * N_DIGITS;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BUF_W-1:0]    fbuf_q, fbuf_d;
  logic [BUF_W-1:0]    pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                ack_q, ack_d;
  logic                fd_q, fd_d;
  logic [3:0]          dec_q, dec_d;
  logic [0:6]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                slot_end_c, frame_wrap_c, drive_start_c, suppress_c;

  function automatic logic [3:0] nibble_at(input logic [BUF_W-1:0] b,
                                           input logic [IDX_W-1:0] idx);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IDX_W'(i) == idx) n = b[i*4 +: 4];
    end
    return n;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit is dark when it and every more significant digit are zero; digit 0 always shows.
  function automatic logic leading_zero(input logic [BUF_W-1:0] b,
                                        input logic [IDX_W-1:0] idx);
    logic z;
    z = (idx != '0);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if ((IDX_W'(i) >= idx) && (b[i*4 +: 4] != 4'd0)) z = 1'b0;
    end
    return z;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fbuf_d      = fbuf_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    ack_d       = 1'b0;
    fd_d        = 1'b0;
    an_d        = an_q;
    seg_d       = seg_q;

    slot_end_c   = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    frame_wrap_c = slot_end_c && (idx_q == IDX_W'(N_DIGITS - 1));

    cnt_d = slot_end_c ? '0 : cnt_q + CNT_W'(1);
    if (slot_end_c) idx_d = frame_wrap_c ? '0 : idx_q + IDX_W'(1);

    state_d       = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
    drive_start_c = (state_q == ST_BLANK) && (state_d == ST_DRIVE);

`ifdef LEADING_ZERO_BLANK_EN
    suppress_c = leading_zero(fbuf_q, idx_q);
`else
    suppress_c = 1'b0;
`endif

    // New values commit only at the frame wrap; a load on the wrap edge itself wins.
    if (frame_wrap_c) begin
      fd_d       = 1'b1;
      pend_vld_d = 1'b0;
      if (load) begin
        fbuf_d = value;
        ack_d  = 1'b1;
      end else if (pend_vld_q) begin
        fbuf_d = pend_q;
        ack_d  = 1'b1;
      end
    end else if (load) begin
      pend_d     = value;
      pend_vld_d = 1'b1;
    end

    if (state_d == ST_BLANK) begin
      an_d  = '1;
      seg_d = '1;
    end else if (drive_start_c && !suppress_c) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = seg_in;
    end

    dec_d = nibble_at(fbuf_d, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      fbuf_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      fd_q       <= 1'b0;
      dec_q      <= 4'd0;
      seg_q      <= '1;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      fbuf_q     <= fbuf_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      fd_q       <= fd_d;
      dec_q      <= dec_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign ack        = ack_q;
  assign frame_done = fd_q;
  assign dec_in     = dec_q;
  assign seg_out    = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: scan timing, load/ack handshake, reset, random loads
// against a cycle-count-based reference model.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        ack;
  logic [3:0]  dec_in;
  logic [0:6]  seg_in;
  logic [0:6]  seg_out;
  logic [3:0]  an;
  logic        frame_done;

  int vec = 0;
  int err = 0;

  // reference model state: cycles since reset release, committed and pending values
  int          t;
  logic [15:0] m_buf, m_pend;
  bit          m_flag, exp_ack, exp_fd;

  display_scan_ctrl #(.N_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .ack(ack), .dec_in(dec_in),
    .seg_in(seg_in), .seg_out(seg_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [0:6] dec7(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111101;
    endcase
  endfunction

  assign seg_in = dec7(dec_in);

  function automatic int cur_digit();
    return (t / SLOT) % N;
  endfunction

  function automatic logic [3:0] m_nib(input int d);
    return m_buf[d*4 +: 4];
  endfunction

  function automatic logic m_sup(input int d);
    logic z;
    z = (d > 0) && ((m_buf >> (4 * d)) == 16'h0);
`ifndef LEADING_ZERO_BLANK_EN
    z = 1'b0;
`endif
    return z;
  endfunction

  function automatic logic [3:0] exp_an();
    int d;
    d = cur_digit();
    if ((t % SLOT) < BLANK || m_sup(d)) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [0:6] exp_seg();
    int d;
    d = cur_digit();
    if ((t % SLOT) < BLANK || m_sup(d)) return 7'b1111111;
    return dec7(m_nib(d));
  endfunction

  task automatic model_reset();
    t = 0; m_buf = 16'h0; m_pend = 16'h0; m_flag = 0; exp_ack = 0; exp_fd = 0;
  endtask

  // Apply one clock edge with the given load request and advance the model.
  task automatic tick(input bit l, input logic [15:0] v);
    load = l; value = v;
    @(posedge clk); #1;
    load = 1'b0;
    t++;
    exp_ack = 0;
    exp_fd  = (t % FRAME == 0);
    if (exp_fd) begin
      if (l) begin m_buf = v; exp_ack = 1; end
      else if (m_flag) begin m_buf = m_pend; exp_ack = 1; end
      m_flag = 0;
    end else if (l) begin
      m_pend = v; m_flag = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (an !== 4'hF) begin err++; $display("FAIL rst_an got %b want 1111", an); end
    vec++; if (seg_out !== 7'h7F) begin err++; $display("FAIL rst_seg got %b want 1111111", seg_out); end
    vec++; if ({dec_in, ack, frame_done} !== 6'b0) begin err++;
      $display("FAIL rst_misc dec=%h ack=%b fd=%b want 0", dec_in, ack, frame_done); end
    #1 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(0, 16'h0);
      vec++; if (an !== exp_an()) begin err++; $display("FAIL scan_an t=%0d got %b want %b", t, an, exp_an()); end
      if (t == 2) begin
        vec++; if (an !== 4'b1110 || seg_out !== 7'b0000001 || dec_in !== 4'd0) begin err++;
          $display("FAIL first_drive an=%b seg=%b dec=%h want 1110 0000001 0", an, seg_out, dec_in); end
      end
      if (t == 8) begin
        vec++; if (an !== 4'hF || dec_in !== m_nib(1)) begin err++;
          $display("FAIL slot1_start an=%b dec=%h want 1111 %h", an, dec_in, m_nib(1)); end
      end
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] seq_d [4];
    logic [0:6] seq_s [4];
    seq_d = '{4'd4, 4'd3, 4'd2, 4'd1};
    seq_s = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    while (t % FRAME != 3) tick(0, 16'h0);
    tick(1, 16'h1234);
    while (t % FRAME != 0) begin
      tick(0, 16'h0);
      vec++; if (ack !== exp_ack || frame_done !== exp_fd) begin err++;
        $display("FAIL commit_pulse t=%0d ack=%b fd=%b want %b %b", t, ack, frame_done, exp_ack, exp_fd); end
    end
    vec++; if (ack !== 1'b1 || frame_done !== 1'b1) begin err++;
      $display("FAIL commit_wrap ack=%b fd=%b want 1 1", ack, frame_done); end
    for (int d = 0; d < N; d++) begin
      while (t % SLOT != BLANK) tick(0, 16'h0);
      vec++; if (dec_in !== seq_d[d] || seg_out !== seq_s[d]) begin err++;
        $display("FAIL frame_seq d=%0d dec=%h seg=%b want %h %b", d, dec_in, seg_out, seq_d[d], seq_s[d]); end
      tick(0, 16'h0);
    end
  endtask

  task automatic test_overwrite();
    int acks;
    acks = 0;
    while (t % FRAME != 10) tick(0, 16'h0);
    tick(1, 16'h1111);
    while (t % FRAME != 20) begin tick(0, 16'h0); acks += int'(ack); end
    tick(1, 16'h2222);
    while (t % FRAME != 0) begin tick(0, 16'h0); acks += int'(ack); end
    vec++; if (acks !== 1) begin err++; $display("FAIL overwrite_acks got %0d want 1", acks); end
    vec++; if (dec_in !== 4'h2) begin err++; $display("FAIL overwrite_buf dec=%h want 2", dec_in); end
    for (int k = 0; k < FRAME; k++) begin
      tick(0, 16'h0);
      acks += int'(ack);
      vec++; if (dec_in !== 4'h2) begin err++; $display("FAIL overwrite_frame t=%0d dec=%h want 2", t, dec_in); end
    end
    vec++; if (acks !== 1) begin err++; $display("FAIL overwrite_no_extra_ack got %0d want 1", acks); end
  endtask

  task automatic test_wrap_load();
    while ((t + 1) % FRAME != 0) tick(0, 16'h0);
    tick(1, 16'h00A0);
    vec++; if (ack !== 1'b1 || frame_done !== 1'b1 || dec_in !== 4'h0) begin err++;
      $display("FAIL wrap_load ack=%b fd=%b dec=%h want 1 1 0", ack, frame_done, dec_in); end
    while (t % FRAME != SLOT + BLANK) begin
      tick(0, 16'h0);
      vec++; if ($countones(~an) > 1) begin err++; $display("FAIL onehot t=%0d an=%b", t, an); end
    end
    vec++; if (dec_in !== 4'hA || seg_out !== 7'b1111101 || an !== 4'b1101) begin err++;
      $display("FAIL wrap_digit1 dec=%h seg=%b an=%b want a 1111101 1101", dec_in, seg_out, an); end
  endtask

  task automatic test_reset_mid();
    while (t % FRAME != 13) tick(0, 16'h0);
    #2 rst = 1'b1;
    #1;
    vec++; if (an !== 4'hF || seg_out !== 7'h7F) begin err++;
      $display("FAIL async_rst an=%b seg=%b want 1111 1111111", an, seg_out); end
    vec++; if ({dec_in, ack, frame_done} !== 6'b0) begin err++;
      $display("FAIL async_rst_misc dec=%h ack=%b fd=%b want 0", dec_in, ack, frame_done); end
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      tick(0, 16'h0);
      vec++; if (an !== exp_an() || seg_out !== exp_seg() || dec_in !== m_nib(cur_digit())) begin err++;
        $display("FAIL restart t=%0d an=%b seg=%b dec=%h want %b %b %h", t, an, seg_out, dec_in,
                 exp_an(), exp_seg(), m_nib(cur_digit())); end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] an_d2;
    tick(1, 16'h0070);
    while (t % FRAME != 0) tick(0, 16'h0);
    for (int k = 0; k < FRAME; k++) begin
      vec++; if (an !== exp_an() || seg_out !== exp_seg()) begin err++;
        $display("FAIL lzb t=%0d an=%b seg=%b want %b %b", t, an, seg_out, exp_an(), exp_seg()); end
      if (t % FRAME == 2 * SLOT + BLANK) begin
`ifdef LEADING_ZERO_BLANK_EN
        an_d2 = 4'b1111;
`else
        an_d2 = 4'b1011;
`endif
        vec++; if (an !== an_d2) begin err++; $display("FAIL lzb_digit2 an=%b want %b", an, an_d2); end
      end
      if (t % FRAME == SLOT + BLANK) begin
        vec++; if (seg_out !== 7'b0001111) begin err++; $display("FAIL lzb_digit1 seg=%b want 0001111", seg_out); end
      end
      if (t % FRAME == BLANK) begin
        vec++; if (seg_out !== 7'b0000001) begin err++; $display("FAIL lzb_digit0 seg=%b want 0000001", seg_out); end
      end
      tick(0, 16'h0);
    end
  endtask

  task automatic test_random();
    bit          l;
    logic [15:0] v;
    for (int k = 0; k < 800; k++) begin
      l = ($urandom_range(0, 7) == 0) || (((t + 1) % FRAME == 0) && $urandom_range(0, 1) == 1);
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      tick(l, v);
      vec++; if (an !== exp_an()) begin err++; $display("FAIL rnd_an t=%0d got %b want %b", t, an, exp_an()); end
      vec++; if (seg_out !== exp_seg()) begin err++; $display("FAIL rnd_seg t=%0d got %b want %b", t, seg_out, exp_seg()); end
      vec++; if (dec_in !== m_nib(cur_digit())) begin err++;
        $display("FAIL rnd_dec t=%0d got %h want %h", t, dec_in, m_nib(cur_digit())); end
      vec++; if (ack !== exp_ack || frame_done !== exp_fd) begin err++;
        $display("FAIL rnd_pulse t=%0d ack=%b fd=%b want %b %b", t, ack, frame_done, exp_ack, exp_fd); end
      vec++; if ($countones(~an) > 1) begin err++; $display("FAIL rnd_onehot t=%0d an=%b", t, an); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_commit();
    test_overwrite();
    test_wrap_load();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
